// File: rtl/stbc_sm_encoder_if.sv
// ---------------------------------------------------------------------------
// stbc_sm_encoder_if
//
// Groups the two handshake channels of the STBC spatial-modulation encoder.
//   data_in_valid / data_in / data_in_ready : 12-bit word intake
//                                             ([11:8] k, [7:4] s1, [3:0] s2)
//   tx_valid / tx_ready                     : output sample handshake
//   tx_r / tx_i                             : sample, signed Q-format, N bits
//   tx_slot / tx_ant / tx_last              : sample position tags
//   tx_done                                 : one-cycle end-of-block pulse
//
// modport master : the environment (word source and sample sink)
// modport slave  : the encoder
// ---------------------------------------------------------------------------
interface stbc_sm_encoder_if #(
    parameter int N = 32
);
    logic         data_in_valid;
    logic [11:0]  data_in;
    logic         data_in_ready;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] tx_r;
    logic [N-1:0] tx_i;
    logic         tx_slot;
    logic [1:0]   tx_ant;
    logic         tx_last;
    logic         tx_done;

    modport master (
        output data_in_valid, data_in, tx_ready,
        input  data_in_ready, tx_valid, tx_r, tx_i, tx_slot, tx_ant, tx_last, tx_done
    );

    modport slave (
        input  data_in_valid, data_in, tx_ready,
        output data_in_ready, tx_valid, tx_r, tx_i, tx_slot, tx_ant, tx_last, tx_done
    );
endinterface

// File: rtl/stbc_sm_encoder.sv
// ---------------------------------------------------------------------------
// stbc_sm_encoder
//
// Accepts one 12-bit word (dispersion index k, 16-QAM symbols s1 and s2) and
// streams the 4x2 STBC-SM transmit matrix as 8 complex samples: slot 0 on
// antennas 0..3, then slot 1 on antennas 0..3. A rotated Alamouti block sits
// on the antenna pair selected by k[3:2]; k[1:0] picks the rotation.
//
// Ports:
//   CLOCK_50   : clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   bus        : stbc_sm_encoder_if.slave (word intake + sample stream)
// ---------------------------------------------------------------------------
module stbc_sm_encoder #(
    parameter int N      = 32,
    parameter int Q      = 22,
    parameter int A_UNIT = 1326355
) (
    input  logic               CLOCK_50,
    input  logic               sys_rst_n,
    stbc_sm_encoder_if.slave   bus
);

    // Level 3 needs two integer bits above the fraction plus sign.
    if (Q > N - 3) begin : g_q_range
        $error("stbc_sm_encoder: Q leaves no headroom for level 3");
    end

    localparam logic signed [N-1:0] A1 = N'(A_UNIT);
    localparam logic signed [N-1:0] A3 = (A1 <<< 1) + A1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [11:0] word_q,  word_d;

    logic accept;
    logic emit;

    // Gray 16-QAM: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
    function automatic logic signed [N-1:0] qam_level(input logic [1:0] code);
        logic signed [N-1:0] lvl;
        case (code)
            2'b00:   lvl = -A3;
            2'b01:   lvl = -A1;
            2'b11:   lvl =  A1;
            default: lvl =  A3;
        endcase
        return lvl;
    endfunction

    // ---------------------------------------------------------------- FSM
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        accept  = bus.data_in_valid && (state_q != S_EMIT);
        emit    = (state_q == S_EMIT);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EMIT;
                    cnt_d   = 3'd0;
                    word_d  = bus.data_in;
                end
            end
            S_EMIT: begin
                if (bus.tx_ready) begin
                    if (cnt_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                // Back-to-back words skip IDLE entirely.
                if (accept) begin
                    state_d = S_EMIT;
                    cnt_d   = 3'd0;
                    word_d  = bus.data_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge CLOCK_50 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            word_q  <= 12'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // ------------------------------------------------------------ datapath
    logic signed [N-1:0] s1_r, s1_i, s2_r, s2_i;
    logic signed [N-1:0] ent_r, ent_i, rot_r, rot_i;
    logic [1:0]          ant_a, ant_b;
    logic [1:0]          ant;
    logic                slot;

    always_comb begin
        s1_r = qam_level(word_q[7:6]);
        s1_i = qam_level(word_q[5:4]);
        s2_r = qam_level(word_q[3:2]);
        s2_i = qam_level(word_q[1:0]);
        ant  = cnt_q[1:0];
        slot = cnt_q[2];

        case (word_q[11:10])
            2'd0:    begin ant_a = 2'd0; ant_b = 2'd1; end
            2'd1:    begin ant_a = 2'd2; ant_b = 2'd3; end
            2'd2:    begin ant_a = 2'd0; ant_b = 2'd2; end
            default: begin ant_a = 2'd1; ant_b = 2'd3; end
        endcase

        // Slot 0: (s1, s2); slot 1: (-conj(s2), conj(s1)).
        ent_r = '0;
        ent_i = '0;
        if (ant == ant_a) begin
            ent_r = slot ? -s2_r : s1_r;
            ent_i = slot ?  s2_i : s1_i;
        end else if (ant == ant_b) begin
            ent_r = slot ?  s1_r : s2_r;
            ent_i = slot ? -s1_i : s2_i;
        end

        // Rotation by j^k[1:0]; negating an idle-antenna zero stays exactly 0.
        case (word_q[9:8])
            2'd0:    begin rot_r =  ent_r; rot_i =  ent_i; end
            2'd1:    begin rot_r = -ent_i; rot_i =  ent_r; end
            2'd2:    begin rot_r = -ent_r; rot_i = -ent_i; end
            default: begin rot_r =  ent_i; rot_i = -ent_r; end
        endcase
    end

    // Outputs are gated by state so reset forces them to 0 immediately.
    always_comb begin
        bus.data_in_ready = !emit;
        bus.tx_valid      = emit;
        bus.tx_r          = emit ? rot_r : '0;
        bus.tx_i          = emit ? rot_i : '0;
        bus.tx_slot       = emit & slot;
        bus.tx_ant        = emit ? ant : 2'd0;
        bus.tx_last       = emit & (cnt_q == 3'd7);
        bus.tx_done       = (state_q == S_DONE);
    end

endmodule

// File: doc/stbc_sm_encoder.md
Name: stbc_sm_encoder

Overview:
- Transmit-side encoder that produces the 4x2 transmit matrix the system decoder consumes.
- Takes one 12-bit data word and splits it three ways: a 4-bit dispersion-matrix index, plus two 4-bit 16-QAM symbols.
- Builds a rotated Alamouti block on a selected antenna pair.
- Streams the 8 complex entries in signed Q-format (N=32, Q=22), matching the decoder's sample format, with valid/ready backpressure.

Parameters:
N, 32, sample word width (signed, two's complement)
Q, 22, fractional bits
A_UNIT, 1326355, 16-QAM unit amplitude = round(2^Q/sqrt(10)); level 3 = 3*A_UNIT via shift-add

Ports:
CLOCK_50  in  1  clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
data_in_valid  in  1  data word valid
data_in  in  12  [11:8] matrix index k, [7:4] symbol s1, [3:0] symbol s2
data_in_ready  out  1  encoder can accept a word
tx_valid  out  1  output sample valid
tx_ready  in  1  downstream accepts sample
tx_r  out  N  real part of sample, Q-format
tx_i  out  N  imaginary part of sample, Q-format
tx_slot  out  1  time slot of sample (0/1)
tx_ant  out  2  transmit antenna of sample (0..3)
tx_last  out  1  high with the 8th sample
tx_done  out  1  one-cycle pulse after final sample handshake

Behaviour:
- Reset (async, sys_rst_n=0):
  - FSM goes to IDLE; sample counter cleared.
  - All outputs 0, except data_in_ready=1.
  - Reset mid-stream aborts the block; no tx_done.
- FSM states:
  - IDLE: data_in_ready=1. A handshake (data_in_valid & data_in_ready) latches data_in and goes to EMIT; the counter clears to 0.
  - EMIT: data_in_ready=0; tx_valid=1. Counter c (0..7) advances only on tx_valid & tx_ready. The handshake at c=7 goes to DONE.
  - DONE: exactly one cycle; tx_done=1, tx_valid=0, data_in_ready=1. A handshake here goes directly to EMIT; otherwise go to IDLE.
- Latency: word accepted at edge e gives sample 0 valid after edge e. With tx_ready=1 throughout: 8 consecutive samples, then a DONE cycle, i.e. 9 cycles per word minimum.
- Sample order: c=0..3 is slot 0, antennas 0..3; c=4..7 is slot 1, antennas 0..3. tx_slot=c[2], tx_ant=c[1:0], tx_last=(c==7).
- Stall: while tx_valid=1 and tx_ready=0, tx_r/tx_i/tx_slot/tx_ant/tx_last hold stable.
- 16-QAM mapping (Gray), per symbol:
  - Bits [3:2] give I, bits [1:0] give Q.
  - Code to level: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
  - Value = level*A_UNIT.
- Antenna pair (a,b) from k[3:2]: 0 -> (0,1), 1 -> (2,3), 2 -> (0,2), 3 -> (1,3).
- Alamouti block:
  - Slot 0: ant a = s1, ant b = s2.
  - Slot 1: ant a = -conj(s2), ant b = conj(s1).
  - All other antennas output 0+0j.
- Rotation by k[1:0] on nonzero entries, applied after Alamouti: 0: x; 1: j*x = (-i, r); 2: -x; 3: -j*x = (i, -r). No multipliers.
- Width: all values fit well within N bits; negation never overflows. Zero entries are exactly 0 (no -0 artefacts in two's complement).
- data_in_valid while not ready is ignored; the word is not captured.

Test Plan:
- Word 12'h0F0 (k=0, s1=1111, s2=0000), tx_ready=1 -> 8 back-to-back samples:
  - c0 = (1326355, 1326355)
  - c1 = (-3979065, -3979065)
  - c2, c3 = 0
  - c4 = (3979065, -3979065)
  - c5 = (1326355, -1326355)
  - c6, c7 = 0
  - tx_last on c7; tx_done 1 cycle after c7; data_in_ready low during EMIT.
- Word 12'h5F0 (pair (2,3), rotation j) -> c0, c1, c4, c5 = 0, and:
  - c2 = (-1326355, 1326355)
  - c3 = (3979065, -3979065)
  - c6 = (3979065, 3979065)
  - c7 = (1326355, 1326355)
- Backpressure: tx_ready toggled 1,0,0,1,... during 12'h0F0 -> each sample held stable while stalled; exactly 8 handshakes, in order; tx_done exactly once.
- Back-to-back: second word presented with data_in_valid held high -> accepted in the DONE cycle; the next block's sample 0 appears the following cycle; no idle gap beyond DONE.
- All 16 symbol codes, with k=8 (pair (0,2), no rotation) -> c0 real/imag match the Gray level table (+-1326355, +-3979065); c1, c3, c5, c7 = 0.
- Reset asserted at c=3 -> outputs 0 and data_in_ready=1 immediately (asynchronously), no tx_done; after release, a new word encodes correctly from c=0.
